core_dispatch_queue: RTL and testbench

Parametrised in-order multi-issue dispatch stage with a circular instruction buffer, placed between decode and the execution units (ALU lanes, mul, ldst, branch). It accepts up to ISSUE decoded instructions per cycle and buffers them in program order. Each cycle it dispatches the longest hazard-free in-order prefix of up to ISSUE instructions from the head. It replaces the fixed two-wide, one-entry-hold dispatch with a configurable width and depth, and adds structural-hazard arbitration.

---
 rtl/core_dispatch_queue.sv | 175 +++++++++++++++++
 tb/tb_core_dispatch_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch_queue.sv
// rtl/core_dispatch_queue.sv - in-order multi-issue dispatch queue with RAW and structural hazard arbitration
// Decode word layout (MSB..LSB): rd, ra, rb, uses_ra, uses_rb, writeback, alu, execute, mul, ldst, branch.
module core_dispatch_queue #(
  parameter int ISSUE = 2,
  parameter int DEPTH = 8,
  localparam int REG_W = 5,
  localparam int DEC_W = 3 * REG_W + 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = (ISSUE > 1) ? $clog2(ISSUE) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ISSUE-1:0]              in_valid,
  input  logic [ISSUE-1:0][DEC_W-1:0]   in_dec,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic [(1<<REG_W)-1:0]         busy_mask,
  input  logic                          mul_busy,
  input  logic                          ldst_busy,
  input  logic                          branch_busy,
  output logic [ISSUE-1:0]              start_alu,
  output logic                          start_mul,
  output logic                          start_ldst,
  output logic                          start_branch,
  output logic [ISSUE-1:0][DEC_W-1:0]   issue_dec,
  output logic [SW-1:0]                 single_slot,
  output logic [CW-1:0]                 count
);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic             uses_ra;
    logic             uses_rb;
    logic             writeback;
    logic             alu;
    logic             execute;
    logic             mul;
    logic             ldst;
    logic             branch;
  } dec_t;

  dec_t               buf_q [DEPTH];
  dec_t               buf_d [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ISSUE-1:0]   start_alu_q, start_alu_d;
  logic               start_mul_q, start_mul_d;
  logic               start_ldst_q, start_ldst_d;
  logic               start_branch_q, start_branch_d;
  logic [SW-1:0]      single_slot_q, single_slot_d;
  dec_t [ISSUE-1:0]   issue_dec_q, issue_dec_d;

  dec_t               win [ISSUE];
  logic [ISSUE-1:0]   disp;
  logic [CW-1:0]      enq, deq;
  logic               accept, stop, unit_taken, ok, is_unit;

  // Credit comes only from the registered count; dispatches this cycle do not free space early.
  assign in_ready = !flush && (int'(count_q) + ISSUE <= DEPTH);
  assign accept   = in_valid[0] && in_ready;

  always_comb begin
    buf_d = buf_q;
    enq   = '0;
    for (int l = 0; l < ISSUE; l++) begin
      if (accept && in_valid[l]) begin
        buf_d[tail_q + PW'(l)] = in_dec[l];
        enq = enq + 1'b1;
      end
    end
  end

  always_comb begin
    disp           = '0;
    deq            = '0;
    stop           = 1'b0;
    unit_taken     = 1'b0;
    ok             = 1'b0;
    is_unit        = 1'b0;
    start_alu_d    = '0;
    start_mul_d    = 1'b0;
    start_ldst_d   = 1'b0;
    start_branch_d = 1'b0;
    single_slot_d  = '0;
    for (int i = 0; i < ISSUE; i++) begin
      win[i] = buf_q[head_q + PW'(i)];
      ok = !stop && (CW'(i) < count_q);
      if (win[i].uses_ra && busy_mask[win[i].ra]) ok = 1'b0;
      if (win[i].uses_rb && busy_mask[win[i].rb]) ok = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (disp[j] && win[j].writeback &&
            ((win[i].uses_ra && win[i].ra == win[j].rd) ||
             (win[i].uses_rb && win[i].rb == win[j].rd))) ok = 1'b0;
      end
      // mul, ldst and branch share one start slot per cycle.
      is_unit = win[i].execute && (win[i].mul || win[i].ldst || win[i].branch);
      if (is_unit && (unit_taken || (win[i].mul && mul_busy) ||
                      (win[i].ldst && ldst_busy) || (win[i].branch && branch_busy))) ok = 1'b0;
      if (ok) begin
        disp[i]        = 1'b1;
        deq            = deq + 1'b1;
        start_alu_d[i] = win[i].alu;
        if (is_unit) begin
          unit_taken     = 1'b1;
          single_slot_d  = SW'(i);
          start_mul_d    = win[i].mul;
          start_ldst_d   = win[i].ldst;
          start_branch_d = win[i].branch;
        end
        if (win[i].execute && win[i].branch) stop = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
    for (int i = 0; i < ISSUE; i++) issue_dec_d[i] = win[i];
    if (flush) begin
      start_alu_d    = '0;
      start_mul_d    = 1'b0;
      start_ldst_d   = 1'b0;
      start_branch_d = 1'b0;
      single_slot_d  = '0;
    end
  end

  always_comb begin
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + deq[PW-1:0];
      tail_d  = tail_q + enq[PW-1:0];
      count_d = count_q + enq - deq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      start_alu_q    <= '0;
      start_mul_q    <= 1'b0;
      start_ldst_q   <= 1'b0;
      start_branch_q <= 1'b0;
      single_slot_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      start_alu_q    <= start_alu_d;
      start_mul_q    <= start_mul_d;
      start_ldst_q   <= start_ldst_d;
      start_branch_q <= start_branch_d;
      single_slot_q  <= single_slot_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q       <= buf_d;
    issue_dec_q <= issue_dec_d;
  end

  assign start_alu    = start_alu_q;
  assign start_mul    = start_mul_q;
  assign start_ldst   = start_ldst_q;
  assign start_branch = start_branch_q;
  assign single_slot  = single_slot_q;
  assign count        = count_q;
  assign issue_dec    = issue_dec_q;

endmodule

// File: tb/tb_core_dispatch_queue.sv
// tb/tb_core_dispatch_queue.sv - table-driven, directed and randomized model checks of core_dispatch_queue
module tb_core_dispatch_queue;
  localparam int ISSUE = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 23;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           in_valid;
  logic [1:0][DW-1:0]   in_dec;
  logic                 in_ready;
  logic                 flush;
  logic [31:0]          busy_mask;
  logic                 mul_busy, ldst_busy, branch_busy;
  logic [1:0]           start_alu;
  logic                 start_mul, start_ldst, start_branch;
  logic [1:0][DW-1:0]   issue_dec;
  logic [0:0]           single_slot;
  logic [3:0]           count;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  core_dispatch_queue #(.ISSUE(ISSUE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dec(in_dec), .in_ready(in_ready),
    .flush(flush), .busy_mask(busy_mask), .mul_busy(mul_busy), .ldst_busy(ldst_busy),
    .branch_busy(branch_busy), .start_alu(start_alu), .start_mul(start_mul),
    .start_ldst(start_ldst), .start_branch(start_branch), .issue_dec(issue_dec),
    .single_slot(single_slot), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int rd, input int ra, input int rb,
      input bit ura, input bit urb, input bit wb, input bit alu, input bit ex,
      input bit mul, input bit ldst, input bit br);
    return {rd[4:0], ra[4:0], rb[4:0], ura, urb, wb, alu, ex, mul, ldst, br};
  endfunction

  function automatic logic [DW-1:0] alu_op(input int rd, input int ra, input int rb);
    return mk(rd, ra, rb, 1, 1, 1, 1, 0, 0, 0, 0);
  endfunction

  function automatic logic [DW-1:0] mul_op(input int rd, input int ra, input int rb);
    return mk(rd, ra, rb, 1, 1, 1, 0, 1, 1, 0, 0);
  endfunction

  // reads r3 only, so busy_mask bit 3 blocks it; rd tags program order
  function automatic logic [DW-1:0] tag_op(input int k);
    return mk(8 + k, 3, 0, 1, 0, 1, 1, 0, 0, 0, 0);
  endfunction

  function automatic logic [4:0] f_rd(input logic [DW-1:0] x); return x[22:18]; endfunction
  function automatic logic [4:0] f_ra(input logic [DW-1:0] x); return x[17:13]; endfunction
  function automatic logic [4:0] f_rb(input logic [DW-1:0] x); return x[12:8];  endfunction

  function automatic logic [DW-1:0] rnd_insn();
    int k  = int'($urandom_range(0, 4));
    int rd = int'($urandom_range(0, 7));
    int ra = int'($urandom_range(0, 7));
    int rb = int'($urandom_range(0, 7));
    bit ua = bit'($urandom_range(0, 1));
    bit ub = bit'($urandom_range(0, 1));
    case (k)
      2:       return mk(rd, ra, rb, ua, ub, 1, 0, 1, 1, 0, 0);
      3:       return mk(rd, ra, rb, ua, ub, bit'($urandom_range(0, 1)), 0, 1, 0, 1, 0);
      4:       return mk(rd, ra, rb, ua, ub, 0, 0, 1, 0, 0, 1);
      default: return mk(rd, ra, rb, ua, ub, 1, 1, 0, 0, 0, 0);
    endcase
  endfunction

  task automatic drive(input logic [1:0] iv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_dec[0] = d0;
    in_dec[1] = d1;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    logic [1:0] iv;
    logic [DW-1:0] d0, d1, e, o;
    logic fl, exp_rdy, unit, ok;
    logic [1:0] ea;
    logic em, el, eb;
    logic [0:0] ess;
    int n, r, exp_cnt;
    r  = int'($urandom_range(0, 3));
    iv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    d0 = rnd_insn();
    d1 = rnd_insn();
    fl = ($urandom_range(0, 31) == 0);
    drive(iv, d0, d1, fl);
    busy_mask   = $urandom_range(0, 255) & $urandom_range(0, 255);
    mul_busy    = ($urandom_range(0, 3) == 0);
    ldst_busy   = ($urandom_range(0, 3) == 0);
    branch_busy = ($urandom_range(0, 3) == 0);
    #1;
    exp_rdy = !fl && (DEPTH - mq.size() >= ISSUE);
    chk("rand_in_ready", in_ready, exp_rdy);
    n = 0; unit = 0; ea = 0; em = 0; el = 0; eb = 0; ess = 0;
    begin : window
      bit unit_used;
      unit_used = 0;
      for (int i = 0; i < ISSUE; i++) begin
        if (i >= mq.size()) break;
        e  = mq[i];
        ok = 1;
        if ((e[7] && busy_mask[f_ra(e)]) || (e[6] && busy_mask[f_rb(e)])) ok = 0;
        for (int j = 0; j < i; j++) begin
          o = mq[j];
          if (o[5] && ((e[7] && f_ra(e) == f_rd(o)) || (e[6] && f_rb(e) == f_rd(o)))) ok = 0;
        end
        unit = e[3] && (e[2] || e[1] || e[0]);
        if (unit && (unit_used || (e[2] && mul_busy) || (e[1] && ldst_busy) || (e[0] && branch_busy)))
          ok = 0;
        if (!ok) break;
        n++;
        ea[i] = e[4];
        if (unit) begin
          unit_used = 1;
          ess = 1'(i);
          em = e[2]; el = e[1]; eb = e[0];
        end
        if (e[3] && e[0]) break;
      end
    end
    if (fl) begin
      ea = 0; em = 0; el = 0; eb = 0; ess = 0;
      exp_cnt = 0;
    end else begin
      exp_cnt = mq.size() - n + ((iv[0] && exp_rdy) ? ((iv == 2'b11) ? 2 : 1) : 0);
    end
    tick();
    chk("rand_start_alu", start_alu, ea);
    chk("rand_start_mul", start_mul, em);
    chk("rand_start_ldst", start_ldst, el);
    chk("rand_start_branch", start_branch, eb);
    chk("rand_single_slot", single_slot, ess);
    chk("rand_count", count, exp_cnt);
    if (!fl) for (int i = 0; i < n; i++) chk("rand_issue_dec", issue_dec[i], mq[i]);
    if (fl) mq.delete();
    else begin
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (iv[0] && exp_rdy) begin
        mq.push_back(d0);
        if (iv[1]) mq.push_back(d1);
      end
    end
  endtask

  typedef struct {
    logic [1:0]    iv;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          mb;
    logic          e_rdy;
    logic [1:0]    e_alu;
    logic          e_mul;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    in_valid = 0; in_dec = '0; flush = 0; busy_mask = 0;
    mul_busy = 0; ldst_busy = 0; branch_busy = 0;

    tbl[0]  = '{2'b11, alu_op(1, 2, 3), alu_op(4, 5, 6),   1'b0, 1'b1, 2'b00, 1'b0, 4'd2};
    tbl[1]  = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b11, 1'b0, 4'd0};
    tbl[2]  = '{2'b11, alu_op(1, 2, 3), alu_op(5, 1, 4),   1'b0, 1'b1, 2'b00, 1'b0, 4'd2};
    tbl[3]  = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b01, 1'b0, 4'd1};
    tbl[4]  = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b01, 1'b0, 4'd0};
    tbl[5]  = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b00, 1'b0, 4'd0};
    tbl[6]  = '{2'b11, mul_op(7, 8, 9), mul_op(10, 11, 12), 1'b1, 1'b1, 2'b00, 1'b0, 4'd2};
    tbl[7]  = '{2'b00, '0, '0,                             1'b1, 1'b1, 2'b00, 1'b0, 4'd2};
    tbl[8]  = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b00, 1'b1, 4'd1};
    tbl[9]  = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b00, 1'b1, 4'd0};
    tbl[10] = '{2'b00, '0, '0,                             1'b0, 1'b1, 2'b00, 1'b0, 4'd0};

    repeat (2) tick();
    chk("reset_count", count, 0);
    chk("reset_start_alu", start_alu, 0);
    chk("reset_start_units", {start_mul, start_ldst, start_branch}, 0);
    chk("reset_single_slot", single_slot, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);

    for (int v = 0; v < 11; v++) begin
      drive(tbl[v].iv, tbl[v].d0, tbl[v].d1, 1'b0);
      mul_busy = tbl[v].mb;
      #1;
      chk("tbl_in_ready", in_ready, tbl[v].e_rdy);
      tick();
      chk("tbl_start_alu", start_alu, tbl[v].e_alu);
      chk("tbl_start_mul", start_mul, tbl[v].e_mul);
      chk("tbl_count", count, tbl[v].e_cnt);
    end
    mul_busy = 0;

    // busy register stall across the 7 -> 0 wrap
    busy_mask = 32'h8;
    drive(2'b11, alu_op(1, 2, 3), alu_op(4, 5, 6), 1'b0);
    tick();
    chk("busy_count_enq", count, 2);
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, '0, '0, 1'b0);
      tick();
      chk("busy_stall_alu", start_alu, 0);
      chk("busy_stall_count", count, 2);
    end
    busy_mask = 0;
    drive(2'b00, '0, '0, 1'b0);
    tick();
    chk("busy_release_alu", start_alu, 2'b11);
    chk("busy_release_count", count, 0);
    chk("busy_release_rd0", f_rd(issue_dec[0]), 1);
    chk("busy_release_rd1", f_rd(issue_dec[1]), 4);

    // move head/tail to 3, then fill 7 entries spanning index 7 -> 0
    drive(2'b11, alu_op(1, 2, 3), alu_op(4, 5, 6), 1'b0);
    tick();
    drive(2'b01, alu_op(7, 8, 9), '0, 1'b0);
    tick();
    chk("pre_fill_alu", start_alu, 2'b11);
    drive(2'b00, '0, '0, 1'b0);
    tick();
    chk("pre_fill_alu2", start_alu, 2'b01);
    chk("pre_fill_count", count, 0);
    busy_mask = 32'h8;
    for (int g = 0; g < 3; g++) begin
      drive(2'b11, tag_op(2 * g), tag_op(2 * g + 1), 1'b0);
      chk("fill_in_ready", in_ready, 1);
      tick();
      chk("fill_count", count, 2 * g + 2);
    end
    drive(2'b01, tag_op(6), '0, 1'b0);
    chk("fill_in_ready_6", in_ready, 1);
    tick();
    chk("fill_count_7", count, 7);
    drive(2'b11, alu_op(20, 21, 22), alu_op(23, 24, 25), 1'b0);
    chk("full_in_ready", in_ready, 0);
    busy_mask = 0;
    #1;
    chk("full_in_ready_dispatching", in_ready, 0);
    tick();
    chk("full_count_after", count, 5);
    chk("drain_rd0_0", f_rd(issue_dec[0]), 8);
    chk("drain_rd1_0", f_rd(issue_dec[1]), 9);
    for (int p = 1; p < 3; p++) begin
      drive(2'b00, '0, '0, 1'b0);
      tick();
      chk("drain_alu", start_alu, 2'b11);
      chk("drain_rd0", f_rd(issue_dec[0]), 8 + 2 * p);
      chk("drain_rd1", f_rd(issue_dec[1]), 9 + 2 * p);
      chk("drain_count", count, 5 - 2 * p);
    end
    drive(2'b00, '0, '0, 1'b0);
    tick();
    chk("drain_last_alu", start_alu, 2'b01);
    chk("drain_last_rd", f_rd(issue_dec[0]), 14);
    chk("drain_last_count", count, 0);

    // flush with 5 buffered and a group offered
    busy_mask = 32'h8;
    drive(2'b11, tag_op(0), tag_op(1), 1'b0);
    tick();
    drive(2'b11, tag_op(2), tag_op(3), 1'b0);
    tick();
    drive(2'b01, tag_op(4), '0, 1'b0);
    tick();
    chk("flush_pre_count", count, 5);
    drive(2'b11, alu_op(1, 2, 3), alu_op(4, 5, 6), 1'b1);
    busy_mask = 0;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_count", count, 0);
    chk("flush_start_alu", start_alu, 0);
    chk("flush_start_units", {start_mul, start_ldst, start_branch}, 0);
    drive(2'b00, '0, '0, 1'b0);
    chk("post_flush_in_ready", in_ready, 1);
    tick();
    chk("post_flush_count", count, 0);
    chk("post_flush_alu", start_alu, 0);

    mq.delete();
    for (int c = 0; c < 1000; c++) rand_cycle();

    // asynchronous reset mid-operation
    @(negedge clk);
    in_valid = 0;
    flush = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_count", count, 0);
    chk("async_reset_alu", start_alu, 0);
    chk("async_reset_units", {start_mul, start_ldst, start_branch}, 0);
    #1 rst_n = 1'b1;
    mq.delete();
    for (int c = 0; c < 1000; c++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
